// File: rtl/endgame_text_ctrl_if.sv
// Bundle of the endgame text controller's pixel, score and glyph ROM signals.
// The master side is the VGA/game logic plus ROM; the slave side is endgame_text_ctrl.
interface endgame_text_ctrl_if #(
    parameter int SCORE_W = 16
);
    logic               game_over;
    logic               win;
    logic [SCORE_W-1:0] score;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [9:0]         rom_addr;
    logic [7:0]         rom_data;
    logic               busy;
    logic               text_on;

    modport master (
        output game_over, win, score, DrawX, DrawY, rom_data,
        input  rom_addr, busy, text_on
    );

    modport slave (
        input  game_over, win, score, DrawX, DrawY, rom_data,
        output rom_addr, busy, text_on
    );
endinterface

// File: rtl/endgame_text_ctrl.sv
// End-of-game banner sequencer: latches outcome/score, converts score to BCD, drives the glyph ROM.
// Optional macro ENDGAME_ZERO_BLANK_EN blanks leading zero digits of the score.
module endgame_text_ctrl #(
    parameter int X0      = 256,
    parameter int Y0      = 208,
    parameter int SCORE_W = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    endgame_text_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_e;

    localparam logic [4:0] LAST_BIT = 5'(SCORE_W - 1);

    state_e             state_q, state_d;
    logic               go_prev_q;
    logic               win_q, win_d;
    logic [SCORE_W-1:0] sh_q, sh_d;
    logic [19:0]        bcd_q, bcd_d, bcd_adj;
    logic [4:0]         cnt_q, cnt_d;
    logic               rise;
    logic               busy, show;

    logic [10:0]        dx, dy;
    logic [6:0]         col;
    logic               line0, line1;
    logic [5:0]         dig_code [5];
    logic [5:0]         code;
    logic               cell_ok;

    logic [9:0]         rom_addr_q;
    logic [2:0]         bit_q;
    logic               valid_q;
    logic               text_on_q;

    assign rise = bus.game_over & ~go_prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = CONVERT;
            CONVERT: begin
                if (!bus.game_over)         state_d = IDLE;
                else if (cnt_q == LAST_BIT) state_d = SHOW;
            end
            SHOW:    if (!bus.game_over) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONVERT);
        show = (state_q == SHOW);
    end

    assign bus.busy = busy;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                               : bcd_q[4*gi +: 4];
    end

    always_comb begin
        win_d = win_q;
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && rise) begin
            win_d = bus.win;
            sh_d  = bus.score;
            bcd_d = '0;
            cnt_d = '0;
        end else if (state_q == CONVERT) begin
            bcd_d = {bcd_adj[18:0], sh_q[SCORE_W-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 5'd1;
        end
    end

    // Previous game_over resets high so a level already high at release is not an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            go_prev_q <= 1'b1;
            win_q     <= 1'b0;
            sh_q      <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            go_prev_q <= bus.game_over;
            win_q     <= win_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dx    = {1'b0, bus.DrawX} - 11'(X0);
    assign dy    = {1'b0, bus.DrawY} - 11'(Y0);
    assign col   = dx[9:3];
    assign line0 = !dy[10] && (dy[9:4] == 6'd0);
    assign line1 = !dy[10] && (dy[9:4] == 6'd2);

    for (genvar gi = 0; gi < 5; gi++) begin : g_dig
`ifdef ENDGAME_ZERO_BLANK_EN
        if (gi > 0) begin : g_blank
            assign dig_code[gi] = (bcd_q[19:4*gi] == '0) ? 6'd0
                                                         : 6'd18 + {2'b00, bcd_q[4*gi +: 4]};
        end else begin : g_keep
            assign dig_code[gi] = 6'd18 + {2'b00, bcd_q[4*gi +: 4]};
        end
`else
        assign dig_code[gi] = 6'd18 + {2'b00, bcd_q[4*gi +: 4]};
`endif
    end

    always_comb begin
        code    = 6'd0;
        cell_ok = 1'b0;
        if (!dx[10]) begin
            if (line0 && col < 7'd8) begin
                cell_ok = 1'b1;
                case (col[2:0])
                    3'd0:    code = 6'd1;
                    3'd1:    code = 6'd2;
                    3'd2:    code = 6'd3;
                    3'd3:    code = 6'd0;
                    3'd4:    code = win_q ? 6'd15 : 6'd4;
                    3'd5:    code = win_q ? 6'd14 : 6'd2;
                    3'd6:    code = win_q ? 6'd16 : 6'd5;
                    default: code = win_q ? 6'd0  : 6'd6;
                endcase
            end else if (line1 && col < 7'd13) begin
                cell_ok = 1'b1;
                case (col[3:0])
                    4'd0:    code = 6'd9;
                    4'd1:    code = 6'd2;
                    4'd2:    code = 6'd14;
                    4'd3:    code = 6'd16;
                    4'd4:    code = 6'd11;
                    4'd5:    code = 6'd5;
                    4'd6:    code = 6'd17;
                    4'd7:    code = 6'd0;
                    4'd8:    code = dig_code[4];
                    4'd9:    code = dig_code[3];
                    4'd10:   code = dig_code[2];
                    4'd11:   code = dig_code[1];
                    default: code = dig_code[0];
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            bit_q      <= '0;
            valid_q    <= 1'b0;
            text_on_q  <= 1'b0;
        end else begin
            rom_addr_q <= {code, dy[3:0]};
            bit_q      <= dx[2:0];
            valid_q    <= cell_ok & show;
            text_on_q  <= valid_q & bus.rom_data[~bit_q];
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.text_on  = text_on_q;

endmodule

// File: tb/tb_endgame_text_ctrl.sv
// Directed + randomized bench for endgame_text_ctrl against a string/arithmetic reference model.
// Honours ENDGAME_ZERO_BLANK_EN the same way the design does.
module tb_endgame_text_ctrl;

    localparam int X0 = 256;
    localparam int Y0 = 208;
    localparam int SW = 16;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit   m_win;
    int   m_score;
    bit   m_show;

    endgame_text_ctrl_if #(.SCORE_W(SW)) bus ();

    endgame_text_ctrl #(.X0(X0), .Y0(Y0), .SCORE_W(SW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] rom_fn(int a);
        if (a < 16)  return 8'h00;
        if (a == 18) return 8'hC3;
        return 8'((a * 73) ^ (a >> 3) ^ 'h5A);
    endfunction

    assign bus.rom_data = rom_fn(int'(bus.rom_addr));

    function automatic int char_code(byte c);
        case (c)
            "Y": return 1;   "o": return 2;   "u": return 3;   "L": return 4;
            "s": return 5;   "e": return 6;   "r": return 7;   "c": return 8;
            "P": return 9;   "a": return 10;  "t": return 11;  "p": return 12;
            "q": return 13;  "i": return 14;  "W": return 15;  "n": return 16;
            ":": return 17;
            default: return 0;
        endcase
    endfunction

    function automatic int pow10(int k);
        int p = 1;
        repeat (k) p = p * 10;
        return p;
    endfunction

    function automatic int exp_code(int x, int y, bit w, int sc, output bit v);
        int dx, dy, col, k;
        string s;
        v  = 1'b0;
        dx = x - X0;
        dy = y - Y0;
        if (dx < 0 || dy < 0) return 0;
        col = dx / 8;
        if (dy < 16 && col < 8) begin
            if (w) s = "You Win ";
            else   s = "You Lose";
            v = 1'b1;
            return char_code(s[col]);
        end
        if (dy >= 32 && dy < 48 && col < 13) begin
            v = 1'b1;
            if (col < 8) begin
                s = "Points: ";
                return char_code(s[col]);
            end
            k = 12 - col;
`ifdef ENDGAME_ZERO_BLANK_EN
            if (k > 0 && sc < pow10(k)) return 0;
`endif
            return 18 + (sc / pow10(k)) % 10;
        end
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-10s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_pixel(int x, int y, bit chk_addr);
        bit         v;
        int         code, exp_addr, b;
        logic [7:0] rd;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        code     = exp_code(x, y, m_win, m_score, v);
        exp_addr = code * 16 + ((y - Y0) & 15);
        b        = (x - X0) & 7;
        rd       = rom_fn(exp_addr);
        @(posedge Clk); #1;
        if (chk_addr) chk("rom_addr", bus.rom_addr, exp_addr);
        @(posedge Clk); #1;
        chk("text_on", bus.text_on, (m_show && v) ? rd[7-b] : 1'b0);
    endtask

    task automatic start_game(bit w, int sc);
        bus.game_over = 1'b0;
        @(posedge Clk); #1;
        bus.win       = w;
        bus.score     = SW'(sc);
        bus.game_over = 1'b1;
        m_show        = 1'b0;
        chk("busy_pre", bus.busy, 1'b0);
        @(posedge Clk); #1;
        m_win   = w;
        m_score = sc;
        bus.score = SW'($urandom);
        bus.win   = ~w;
        for (int i = 0; i < SW; i++) begin
            chk("busy_conv", bus.busy, 1'b1);
            @(posedge Clk); #1;
        end
        chk("busy_done", bus.busy, 1'b0);
        m_show = 1'b1;
    endtask

    initial begin
        bus.game_over = 1'b0;
        bus.win       = 1'b0;
        bus.score     = '0;
        bus.DrawX     = '0;
        bus.DrawY     = '0;
        m_win = 1'b0; m_score = 0; m_show = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.game_over = 1'($urandom);
            bus.win       = 1'($urandom);
            bus.score     = SW'($urandom);
            bus.DrawX     = 10'($urandom_range(X0, X0 + 100));
            bus.DrawY     = 10'($urandom_range(Y0, Y0 + 47));
            @(posedge Clk); #1;
            chk("rst_addr", bus.rom_addr, 10'd0);
            chk("rst_text", bus.text_on, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
        end
        bus.game_over = 1'b1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("rel_busy", bus.busy, 1'b0);
        end
        check_pixel(X0, Y0 + 2, 1'b1);
        check_pixel(X0 + 8 * 12 + 3, Y0 + 33, 1'b1);

        // Lose, 1234
        start_game(1'b0, 1234);
        check_pixel(X0, Y0 + 2, 1'b1);
        check_pixel(X0 + 32 + 1, Y0 + 5, 1'b1);
        for (int c = 8; c < 13; c++) check_pixel(X0 + 8 * c + c % 8, Y0 + 32 + c, 1'b1);

        // Win, 1234
        start_game(1'b1, 1234);
        check_pixel(X0 + 32, Y0 + 9, 1'b1);
        for (int c = 0; c < 13; c++) check_pixel(X0 + 8 * c + 7 - c % 8, Y0 + 40, 1'b1);

        // Zero score
        start_game(1'b1, 0);
        for (int c = 8; c < 13; c++) check_pixel(X0 + 8 * c, Y0 + 36, 1'b1);

        // Max score and text-block edges
        start_game(1'b0, 65535);
        for (int c = 8; c < 13; c++) check_pixel(X0 + 8 * c + 2, Y0 + 34, 1'b1);
        check_pixel(X0 - 1, Y0 + 34, 1'b1);
        check_pixel(X0 + 8 * 13, Y0 + 34, 1'b1);
        check_pixel(X0 + 8 * 8, Y0 + 16, 1'b1);
        check_pixel(X0, Y0 + 48, 1'b1);

        // Abort mid-conversion, then a full restart
        bus.game_over = 1'b0;
        @(posedge Clk); #1;
        bus.score     = SW'(777);
        bus.game_over = 1'b1;
        m_show        = 1'b0;
        @(posedge Clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("abort_busy", bus.busy, 1'b1);
            @(posedge Clk); #1;
        end
        bus.game_over = 1'b0;
        @(posedge Clk); #1;
        chk("abort_idle", bus.busy, 1'b0);
        check_pixel(X0, Y0 + 2, 1'b0);
        start_game(1'b1, 4321);
        check_pixel(X0 + 8 * 9, Y0 + 33, 1'b1);

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            start_game(1'($urandom), int'($urandom_range(0, 65535)));
            for (int p = 0; p < 10; p++)
                check_pixel(int'($urandom_range(X0 - 8, X0 + 112)),
                            int'($urandom_range(Y0 - 4, Y0 + 52)), 1'b1);
        end

        // Asynchronous reset mid-SHOW
        check_pixel(X0, Y0 + 2, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_addr", bus.rom_addr, 10'd0);
        chk("arst_text", bus.text_on, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        m_win = 1'b0; m_score = 0; m_show = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Asynchronous reset mid-CONVERT, release with game_over high
        start_game(1'b1, 999);
        bus.game_over = 1'b0;
        @(posedge Clk); #1;
        bus.game_over = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("conv_busy", bus.busy, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst2_busy", bus.busy, 1'b0);
        m_win = 1'b0; m_score = 0; m_show = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("rel2_busy", bus.busy, 1'b0);
        end
        check_pixel(X0 + 8 * 11, Y0 + 35, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
